// File: rtl/falu_pkg.sv
// Shared opcodes, FSM state encoding and operand bundle for the falu arbiter.
package falu_pkg;

   localparam logic [1:0] FALU_ADD = 2'b00;
   localparam logic [1:0] FALU_SUB = 2'b01;
   localparam logic [1:0] FALU_MUL = 2'b10;
   localparam logic [1:0] FALU_DIV = 2'b11;

   typedef enum logic [1:0] {ARB_IDLE, ARB_EXEC, ARB_RESP} falu_arb_state_t;

   typedef struct packed {
      logic [1:0]  opf;
      logic [31:0] regb, regc;
   } falu_op_t;

endpackage

// File: rtl/falu.sv
// Combinational single-precision unit: rega = regb (op) regc, truncating rounding.
// Subnormal inputs are flushed to zero; divide by zero returns a signed infinity.
module falu
   import falu_pkg::*;
(
   input  logic [1:0]  opf_i,
   input  logic [31:0] regb_i,
   input  logic [31:0] regc_i,
   output logic [31:0] rega_o
);

   logic        sb, sc, sc_eff, sign_r, swap;
   logic [7:0]  eb, ec;
   logic [23:0] mb, mc;
   logic [24:0] m_big, m_sml, sum;
   logic [47:0] norm;
   int          exp_base, pos;

   function automatic logic [31:0] pack(input logic s, input int e, input logic [22:0] f);
      if (e <= 0) begin
         return {s, 31'd0};
      end else if (e >= 255) begin
         return {s, 8'hFF, 23'd0};
      end else begin
         return {s, e[7:0], f};
      end
   endfunction

   // Per-op mantissa result in norm; final exponent field is exp_base + leading-one position
   always_comb begin
      sb     = regb_i[31];
      sc     = regc_i[31];
      eb     = regb_i[30:23];
      ec     = regc_i[30:23];
      mb     = (eb != 8'd0) ? {1'b1, regb_i[22:0]} : 24'd0;
      mc     = (ec != 8'd0) ? {1'b1, regc_i[22:0]} : 24'd0;
      sc_eff = sc ^ (opf_i == FALU_SUB);
      swap   = ({ec, mc} > {eb, mb});
      m_big  = swap ? {1'b0, mc} : {1'b0, mb};
      m_sml  = swap ? ({1'b0, mb} >> (ec - eb)) : ({1'b0, mc} >> (eb - ec));
      sum    = (sb == sc_eff) ? (m_big + m_sml) : (m_big - m_sml);
      norm     = 48'd0;
      sign_r   = sb ^ sc;
      exp_base = 0;
      case (opf_i)
         FALU_ADD, FALU_SUB: begin
            norm     = {23'd0, sum};
            sign_r   = (sum == 25'd0) ? 1'b0 : (swap ? sc_eff : sb);
            exp_base = int'(swap ? ec : eb) - 23;
         end
         FALU_MUL: begin
            norm     = {24'd0, mb} * {24'd0, mc};
            exp_base = int'(eb) + int'(ec) - 127 - 46;
         end
         FALU_DIV: begin
            norm     = (mc == 24'd0) ? 48'd0 : ({mb, 24'd0} / {24'd0, mc});
            exp_base = int'(eb) - int'(ec) + 127 - 24;
         end
         default: begin
            norm     = 48'd0;
            exp_base = 0;
         end
      endcase
      pos = 0;
      for (int i = 0; i < 48; i++) begin
         if (norm[i]) begin
            pos = i;
         end else begin
            pos = pos;
         end
      end
      if (opf_i == FALU_DIV && mc == 24'd0) begin
         rega_o = {sign_r, 8'hFF, 23'd0};
      end else if (norm == 48'd0) begin
         rega_o = {sign_r, 31'd0};
      end else begin
         rega_o = pack(sign_r, exp_base + pos,
                       23'((pos >= 23) ? (norm >> (pos - 23)) : (norm << (23 - pos))));
      end
   end

endmodule

// File: rtl/falu_arbiter_rr_picker.sv
// Round-robin priority encoder: first valid at or above ptr, wrapping, as one-hot plus index.
module rr_picker #(
   parameter int N     = 4,
   parameter int IDX_W = $clog2(N)
) (
   input  logic [N-1:0]     valid_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     grant_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   int   j;
   logic found;

   // Wrapping search starting at ptr_i
   always_comb begin
      grant_o = '0;
      idx_o   = '0;
      found   = 1'b0;
      j       = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr_i) + k) % N;
         if (!found && valid_i[j]) begin
            found      = 1'b1;
            grant_o[j] = 1'b1;
            idx_o      = IDX_W'(j);
         end else begin
            found = found;
         end
      end
      any_o = found;
   end

endmodule

// File: rtl/falu_arbiter.sv
// Round-robin sharing of one falu across N_REQ requesters with a multicycle hold.
// Define FALU_ARB_STATS_EN to add grant_cnt/stall_cnt saturating statistics outputs.
module falu_arbiter
   import falu_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int LATENCY = 2,
   parameter int ID_W    = $clog2(N_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_REQ-1:0]     req_valid,
   output logic [N_REQ-1:0]     req_ready,
   input  logic [2*N_REQ-1:0]   req_opf,
   input  logic [32*N_REQ-1:0]  req_regb,
   input  logic [32*N_REQ-1:0]  req_regc,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [ID_W-1:0]      rsp_id,
   output logic [31:0]          rsp_rega,
   output logic                 busy
`ifdef FALU_ARB_STATS_EN
   ,output logic [16*N_REQ-1:0] grant_cnt
   ,output logic [15:0]         stall_cnt
`endif
);

   localparam int CNT_W = 4;

   falu_arb_state_t state_q, state_d;
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d, id_q, id_d, rsp_id_q, rsp_id_d, pick_idx;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   falu_op_t        op_q, op_d;
   logic            rsp_valid_q, rsp_valid_d, pick_any;
   logic [31:0]     rsp_rega_q, rsp_rega_d, falu_rega;
   logic [N_REQ-1:0] pick_grant;
   int              sel;

   rr_picker #(.N(N_REQ), .IDX_W(ID_W)) u_picker (
      .valid_i (req_valid),
      .ptr_i   (rr_ptr_q),
      .grant_o (pick_grant),
      .idx_o   (pick_idx),
      .any_o   (pick_any)
   );

   // falu sees only the registered operands so its inputs stay stable during EXEC
   falu u_falu (
      .opf_i  (op_q.opf),
      .regb_i (op_q.regb),
      .regc_i (op_q.regc),
      .rega_o (falu_rega)
   );

   // Next-state and combinational grant
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      cnt_d       = cnt_q;
      op_d        = op_q;
      id_d        = id_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_rega_d  = rsp_rega_q;
      req_ready   = '0;
      sel         = int'(pick_idx);
      case (state_q)
         ARB_IDLE: begin
            req_ready = pick_grant;
            if (pick_any) begin
               op_d.opf  = req_opf[2*sel +: 2];
               op_d.regb = req_regb[32*sel +: 32];
               op_d.regc = req_regc[32*sel +: 32];
               id_d      = pick_idx;
               rr_ptr_d  = (sel == N_REQ - 1) ? '0 : ID_W'(sel + 1);
               cnt_d     = CNT_W'(LATENCY - 1);
               state_d   = ARB_EXEC;
            end else begin
               state_d = ARB_IDLE;
            end
         end
         ARB_EXEC: begin
            if (cnt_q == '0) begin
               rsp_rega_d  = falu_rega;
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
               state_d     = ARB_RESP;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         ARB_RESP: begin
            if (rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ARB_IDLE;
            end else begin
               state_d = ARB_RESP;
            end
         end
         default: begin
            state_d     = ARB_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         rr_ptr_q    <= '0;
         cnt_q       <= '0;
         op_q        <= '0;
         id_q        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rega_q  <= 32'd0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         cnt_q       <= cnt_d;
         op_q        <= op_d;
         id_q        <= id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_rega_q  <= rsp_rega_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_rega  = rsp_rega_q;
   assign busy      = (state_q != ARB_IDLE);

`ifdef FALU_ARB_STATS_EN
   logic [15:0] grant_cnt_q [N_REQ];
   logic [15:0] stall_cnt_q;

   // Saturating per-requester grant counters and response stall counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) grant_cnt_q[i] <= 16'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (state_q == ARB_IDLE && pick_grant[i] && grant_cnt_q[i] != 16'hFFFF) begin
               grant_cnt_q[i] <= grant_cnt_q[i] + 16'd1;
            end else begin
               grant_cnt_q[i] <= grant_cnt_q[i];
            end
         end
         if (state_q == ARB_RESP && !rsp_ready && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end else begin
            stall_cnt_q <= stall_cnt_q;
         end
      end
   end

   // Flatten counters onto the output bus
   always_comb begin
      grant_cnt = '0;
      for (int i = 0; i < N_REQ; i++) grant_cnt[16*i +: 16] = grant_cnt_q[i];
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_falu_arbiter.sv
// Self-checking bench for falu_arbiter: directed scenarios plus random traffic against a
// transaction-level model (integer-valued floats, cycle-accurate handshake expectations).
module tb_falu_arbiter;
   import falu_pkg::*;

   localparam int N  = 4;
   localparam int L  = 2;
   localparam int IW = $clog2(N);

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req_valid, req_ready;
   logic [2*N-1:0]  req_opf;
   logic [32*N-1:0] req_regb, req_regc;
   logic            rsp_valid, rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic [31:0]     rsp_rega;
   logic            busy;
`ifdef FALU_ARB_STATS_EN
   logic [16*N-1:0] grant_cnt;
   logic [15:0]     stall_cnt;
`endif

   falu_arbiter #(.N_REQ(N), .LATENCY(L)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_opf   (req_opf),
      .req_regb  (req_regb),
      .req_regc  (req_regc),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_rega  (rsp_rega),
      .busy      (busy)
`ifdef FALU_ARB_STATS_EN
      ,.grant_cnt (grant_cnt)
      ,.stall_cnt (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: pending requests per requester, and the arbiter's transaction phase
   logic        pend_v   [N];
   logic [1:0]  pend_opf [N];
   logic [31:0] pend_b   [N];
   logic [31:0] pend_c   [N];
   logic [31:0] pend_exp [N];
   int          m_state;   // 0 idle, 1 computing, 2 response offered
   int          m_cnt;
   int          m_ptr;
   int          m_id;
   logic [31:0] m_res;
   int          grants[$];
   int          gcount [N];
   int          stalls;
   bit          rand_mode;
   int          hold_left;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] i2f(input int v);
      int          a, msb;
      logic [31:0] m;
      if (v == 0) return 32'h0;
      a   = (v < 0) ? -v : v;
      msb = $clog2(a + 1) - 1;
      m   = a;
      m   = m << (23 - msb);
      return {(v < 0) ? 1'b1 : 1'b0, 8'(127 + msb), m[22:0]};
   endfunction

   function automatic bit any_pend();
      for (int i = 0; i < N; i++) if (pend_v[i]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic post(input int i, input logic [1:0] opf, input logic [31:0] b,
                       input logic [31:0] c, input logic [31:0] exp);
      pend_v[i] = 1'b1; pend_opf[i] = opf; pend_b[i] = b; pend_c[i] = c; pend_exp[i] = exp;
   endtask

   task automatic gen_op(input int i);
      int x, y, vb, vc, r, op;
      x  = $urandom_range(1, 64);
      y  = $urandom_range(1, 64);
      op = $urandom_range(0, 3);
      vb = ($urandom_range(0, 1) == 1) ? -x : x;
      vc = ($urandom_range(0, 1) == 1) ? -y : y;
      case (op)
         0: r = vb + vc;
         1: r = vb - vc;
         2: r = vb * vc;
         default: begin r = vb; vb = vb * vc; end
      endcase
      post(i, 2'(op), i2f(vb), i2f(vc), i2f(r));
   endtask

   task automatic apply_req();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = pend_v[i];
         req_opf[2*i +: 2]    = pend_v[i] ? pend_opf[i] : 2'($urandom);
         req_regb[32*i +: 32] = pend_v[i] ? pend_b[i] : $urandom;
         req_regc[32*i +: 32] = pend_v[i] ? pend_c[i] : $urandom;
      end
   endtask

   task automatic drive();
      if (rand_mode) begin
         for (int i = 0; i < N; i++) begin
            if (pend_v[i] && $urandom_range(0, 19) == 0) pend_v[i] = 1'b0;
            else if (!pend_v[i] && $urandom_range(0, 3) == 0) gen_op(i);
         end
      end
      apply_req();
      if (m_state == 2 && hold_left > 0) begin
         rsp_ready = 1'b0;
         hold_left--;
      end else if (rand_mode) begin
         rsp_ready = ($urandom_range(0, 2) != 0);
      end else begin
         rsp_ready = 1'b1;
      end
   endtask

   // One clock: check/advance the model at negedge, drive new inputs just after posedge
   task automatic step();
      logic [N-1:0] exp_rdy;
      int           w, j;
      @(negedge clk);
      if (!rst_n) begin
         m_state = 0; m_ptr = 0; stalls = 0;
         for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; gcount[i] = 0; end
      end else begin
         exp_rdy = '0;
         w = -1;
         if (m_state == 0) begin
            for (int k = 0; k < N; k++) begin
               j = (m_ptr + k) % N;
               if (w < 0 && pend_v[j]) w = j;
            end
         end
         if (w >= 0) exp_rdy[w] = 1'b1;
         chk("req_ready", req_ready, exp_rdy);
         chk("busy", busy, m_state != 0);
         chk("rsp_valid", rsp_valid, m_state == 2);
         if (m_state == 2) begin
            chk("rsp_id", rsp_id, m_id);
            chk("rsp_rega", rsp_rega, m_res);
            if (rsp_ready) m_state = 0;
            else if (stalls < 65535) stalls++;
         end else if (m_state == 1) begin
            m_cnt--;
            if (m_cnt == 0) m_state = 2;
         end else if (w >= 0) begin
            // response is offered LATENCY+1 cycles after the accept cycle
            m_state = 1; m_cnt = L; m_id = w; m_res = pend_exp[w];
            m_ptr = (w + 1) % N;
            pend_v[w] = 1'b0;
            grants.push_back(w);
            if (gcount[w] < 65535) gcount[w]++;
         end
      end
      @(posedge clk);
      #1;
      drive();
   endtask

   task automatic run_idle(input int maxc);
      int c;
      c = 0;
      do begin
         step();
         c++;
      end while ((m_state != 0 || any_pend()) && c < maxc);
      chk("drain_timeout", (m_state != 0 || any_pend()), 1'b0);
   endtask

   task automatic do_reset(input int n);
      for (int i = 0; i < N; i++) pend_v[i] = 1'b0;
      rst_n = 1'b0;
      drive();
      repeat (n) step();
      rst_n = 1'b1;
      #1;
      chk("rst_rsp_valid", rsp_valid, 1'b0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_rega", rsp_rega, 32'h0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_req_ready", req_ready, 0);
   endtask

   initial begin
      rst_n = 1'b0; rand_mode = 1'b0; hold_left = 0;
      m_state = 0; m_ptr = 0; m_cnt = 0; m_id = 0; m_res = 32'h0; stalls = 0;
      for (int i = 0; i < N; i++) begin pend_v[i] = 1'b0; gcount[i] = 0; end
      apply_req();
      rsp_ready = 1'b0;
      do_reset(3);

      // single ADD 1+2
      grants.delete();
      post(0, FALU_ADD, 32'h3F800000, 32'h40000000, 32'h40400000);
      apply_req();
      run_idle(20);
      chk("t1_ngrant", grants.size(), 1);
      chk("t1_grant", grants[0], 0);

      // four simultaneous MUL 2*3 granted in order from a fresh pointer
      do_reset(2);
      grants.delete();
      for (int i = 0; i < N; i++) post(i, FALU_MUL, 32'h40000000, 32'h40400000, 32'h40C00000);
      apply_req();
      run_idle(60);
      chk("t2_ngrant", grants.size(), N);
      for (int k = 0; k < N; k++) chk("t2_order", grants[k], k);

      // wrap: after req 2, reqs 0 and 3 -> 3 first
      grants.delete();
      post(2, FALU_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000);
      apply_req();
      run_idle(20);
      post(0, FALU_SUB, 32'h40400000, 32'h3F800000, 32'h40000000);
      post(3, FALU_DIV, 32'h40C00000, 32'h40400000, 32'h40000000);
      apply_req();
      run_idle(40);
      chk("t3_ngrant", grants.size(), 3);
      chk("t3_first", grants[1], 3);
      chk("t3_second", grants[2], 0);

      // back-pressure 5 cycles on SUB 3-1 while another request waits
      grants.delete();
      hold_left = 5;
      post(0, FALU_SUB, 32'h40400000, 32'h3F800000, 32'h40000000);
      apply_req();
      step();
      post(1, FALU_MUL, 32'h40000000, 32'h40400000, 32'h40C00000);
      apply_req();
      run_idle(60);
      chk("t4_order0", grants[0], 0);
      chk("t4_order1", grants[1], 1);

      // reset while computing: no response, pointer back to 0
      post(1, FALU_DIV, 32'h40C00000, 32'h40400000, 32'h40000000);
      apply_req();
      for (int c = 0; c < 10 && m_state != 1; c++) step();
      do_reset(1);
      repeat (6) step();
      grants.delete();
      post(3, FALU_ADD, 32'h40000000, 32'h40000000, 32'h40800000);
      post(1, FALU_ADD, 32'h3F800000, 32'h3F800000, 32'h40000000);
      apply_req();
      run_idle(40);
      chk("t5_first", grants[0], 1);
      chk("t5_second", grants[1], 3);

`ifdef FALU_ARB_STATS_EN
      do_reset(2);
      hold_left = 4;
      for (int r = 0; r < 3; r++) begin
         post(1, FALU_ADD, 32'h3F800000, 32'h40000000, 32'h40400000);
         apply_req();
         run_idle(30);
      end
      chk("t6_grant1", grant_cnt[31:16], 16'd3);
      chk("t6_stall", stall_cnt, 16'd4);
`endif

      // random traffic
      rand_mode = 1'b1;
      repeat (600) step();
      rand_mode = 1'b0;
      run_idle(200);

`ifdef FALU_ARB_STATS_EN
      for (int i = 0; i < N; i++) chk("stats_grant", grant_cnt[16*i +: 16], 16'(gcount[i]));
      chk("stats_stall", stall_cnt, 16'(stalls));
`endif

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
